bp_be_instr_encoder: RTL and testbench

Command-driven RV64 instruction sequencer that turns high-level requests into legal encoded instruction words and presents them on the backend instruction interface the decoder consumes.

---
 rtl/bp_be_instr_encoder.sv | 178 +++++++++++++++++
 tb/tb_bp_be_instr_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_instr_encoder.sv
// RV64 instruction sequencer for debug/boot injection: emits CSR, LI, LD, SD
// and FENCE.I words over a valid/yumi handshake. Option: BP_BE_INSTR_ENCODER_LI_OPT_EN.
module bp_be_instr_encoder #(
    parameter int unsigned vaddr_width_p = 39,
    parameter logic [63:0] inject_pc_p   = 64'd0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic [2:0]               cmd_op_i,
    input  logic [4:0]               cmd_rd_i,
    input  logic [4:0]               cmd_rs1_i,
    input  logic [11:0]              cmd_csr_i,
    input  logic [31:0]              cmd_imm_i,
    output logic                     instr_v_o,
    output logic [31:0]              instr_o,
    output logic [vaddr_width_p-1:0] pc_o,
    output logic                     fe_exc_not_instr_o,
    input  logic                     instr_yumi_i,
    output logic                     done_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } state_e;

    localparam logic [2:0] OP_CSR_RD  = 3'd0;
    localparam logic [2:0] OP_CSR_WR  = 3'd1;
    localparam logic [2:0] OP_LI      = 3'd2;
    localparam logic [2:0] OP_LD      = 3'd3;
    localparam logic [2:0] OP_SD      = 3'd4;
    localparam logic [2:0] OP_FENCE_I = 3'd5;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [11:0] csr_q, csr_d;
    logic [31:0] imm_q, imm_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        op_legal;
    logic        two_word;
    logic [19:0] lui_hi;
    logic [31:0] lui_adj;
    logic [31:0] addiw_w;
    logic [31:0] li_w0;
    logic        li_single;
    logic [31:0] word0;
    logic [31:0] word1;

    assign accept   = cmd_v_i & (state_q == IDLE);
    assign op_legal = (cmd_op_i <= OP_FENCE_I);

    // Bump the upper part when ADDIW will sign-extend a negative low half
    assign lui_hi  = imm_q[31:12] + {19'd0, imm_q[11]};
    assign lui_adj = {lui_hi, rd_q, 7'h37};
    assign addiw_w = {imm_q[11:0], rd_q, 3'b000, rd_q, 7'h1B};

`ifdef BP_BE_INSTR_ENCODER_LI_OPT_EN
    logic addi_ok;
    logic lui_ok;
    assign addi_ok = (imm_q == {{20{imm_q[11]}}, imm_q[11:0]});
    assign lui_ok  = (imm_q[11:0] == 12'd0);
    assign li_single = addi_ok | lui_ok;
    always_comb begin
        li_w0 = lui_adj;
        if (addi_ok) begin
            li_w0 = {imm_q[11:0], 5'd0, 3'b000, rd_q, 7'h13};
        end else if (lui_ok) begin
            li_w0 = {imm_q[31:12], rd_q, 7'h37};
        end
    end
`else
    assign li_single = 1'b0;
    assign li_w0     = lui_adj;
`endif

    assign two_word = (op_q == OP_LI) & ~li_single;

    always_comb begin
        word0 = 32'd0;
        case (op_q)
            OP_CSR_RD:  word0 = {csr_q, 5'd0, 3'b010, rd_q, 7'h73};
            OP_CSR_WR:  word0 = {csr_q, rs1_q, 3'b001, 5'd0, 7'h73};
            OP_LI:      word0 = li_w0;
            OP_LD:      word0 = {imm_q[11:0], rs1_q, 3'b011, rd_q, 7'h03};
            OP_SD:      word0 = {imm_q[11:5], rd_q, rs1_q, 3'b011,
                                 imm_q[4:0], 7'h23};
            OP_FENCE_I: word0 = 32'h0000100F;
            default:    word0 = 32'd0;
        endcase
    end

    assign word1 = addiw_w;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        csr_d   = csr_q;
        imm_d   = imm_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_legal) begin
                        state_d = EMIT0;
                        op_d    = cmd_op_i;
                        rd_d    = cmd_rd_i;
                        rs1_d   = cmd_rs1_i;
                        csr_d   = cmd_csr_i;
                        imm_d   = cmd_imm_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT0: begin
                if (instr_yumi_i) begin
                    if (two_word) begin
                        state_d = EMIT1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            EMIT1: begin
                if (instr_yumi_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            rd_q    <= 5'd0;
            rs1_q   <= 5'd0;
            csr_q   <= 12'd0;
            imm_q   <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            csr_q   <= csr_d;
            imm_q   <= imm_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o        = (state_q == IDLE);
    assign instr_v_o          = (state_q != IDLE);
    assign instr_o            = (state_q == EMIT1) ? word1 :
                                (state_q == EMIT0) ? word0 : 32'd0;
    assign pc_o               = inject_pc_p[vaddr_width_p-1:0];
    assign fe_exc_not_instr_o = 1'b0;
    assign done_o             = done_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_bp_be_instr_encoder.sv
// Directed, table-driven bench for bp_be_instr_encoder plus hand sequences
// for stall, idle yumi and mid-sequence reset.
module tb_bp_be_instr_encoder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        cmd_v_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [4:0]  cmd_rd_i;
    logic [4:0]  cmd_rs1_i;
    logic [11:0] cmd_csr_i;
    logic [31:0] cmd_imm_i;
    logic        instr_v_o;
    logic [31:0] instr_o;
    logic [38:0] pc_o;
    logic        fe_exc_not_instr_o;
    logic        instr_yumi_i;
    logic        done_o;
    logic        err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    bp_be_instr_encoder #(
        .vaddr_width_p(39),
        .inject_pc_p  (64'h0000_00AB_CDEF_0123)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .cmd_v_i           (cmd_v_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_op_i          (cmd_op_i),
        .cmd_rd_i          (cmd_rd_i),
        .cmd_rs1_i         (cmd_rs1_i),
        .cmd_csr_i         (cmd_csr_i),
        .cmd_imm_i         (cmd_imm_i),
        .instr_v_o         (instr_v_o),
        .instr_o           (instr_o),
        .pc_o              (pc_o),
        .fe_exc_not_instr_o(fe_exc_not_instr_o),
        .instr_yumi_i      (instr_yumi_i),
        .done_o            (done_o),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [11:0] csr;
        logic [31:0] imm;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [11:0] csr,
                        input logic [31:0] imm);
        @(negedge clk_i);
        check("ready_before_cmd", cmd_ready_o, 1);
        cmd_v_i   = 1'b1;
        cmd_op_i  = op;
        cmd_rd_i  = rd;
        cmd_rs1_i = rs1;
        cmd_csr_i = csr;
        cmd_imm_i = imm;
        @(negedge clk_i);
        cmd_v_i   = 1'b0;
        cmd_op_i  = 3'($urandom_range(0, 5));
        cmd_rd_i  = 5'($urandom);
        cmd_rs1_i = 5'($urandom);
        cmd_csr_i = 12'($urandom);
        cmd_imm_i = $urandom;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        send(v.op, v.rd, v.rs1, v.csr, v.imm);
        if (v.nw == 0) begin
            check($sformatf("v%0d_err_pulse", idx), err_o, 1);
            check($sformatf("v%0d_err_nov", idx), instr_v_o, 0);
            @(negedge clk_i);
            check($sformatf("v%0d_err_clear", idx), err_o, 0);
            check($sformatf("v%0d_err_nov2", idx), instr_v_o, 0);
            check($sformatf("v%0d_err_ready", idx), cmd_ready_o, 1);
        end else begin
            for (int w = 0; w < v.nw; w++) begin
                check($sformatf("v%0d_w%0d_valid", idx, w), instr_v_o, 1);
                check($sformatf("v%0d_w%0d_instr", idx, w), instr_o,
                      (w == 0) ? v.w0 : v.w1);
                check($sformatf("v%0d_w%0d_nodone", idx, w), done_o, 0);
                check($sformatf("v%0d_w%0d_pc", idx, w), pc_o,
                      39'h00AB_CDEF_0123);
                instr_yumi_i = 1'b1;
                @(negedge clk_i);
                instr_yumi_i = 1'b0;
            end
            check($sformatf("v%0d_done", idx), done_o, 1);
            check($sformatf("v%0d_idle_v", idx), instr_v_o, 0);
            check($sformatf("v%0d_ready", idx), cmd_ready_o, 1);
            @(negedge clk_i);
            check($sformatf("v%0d_done_clear", idx), done_o, 0);
        end
    endtask

    initial begin
        vecs[0] = '{3'd0, 5'd10, 5'd0, 12'hF14, 32'd0, 1,
                    32'hF1402573, 32'd0};
        vecs[1] = '{3'd1, 5'd0, 5'd5, 12'h300, 32'd0, 1,
                    32'h30029073, 32'd0};
        vecs[2] = '{3'd2, 5'd5, 5'd0, 12'h0, 32'h12345FFF, 2,
                    32'h123462B7, 32'hFFF2829B};
`ifdef BP_BE_INSTR_ENCODER_LI_OPT_EN
        vecs[3] = '{3'd2, 5'd5, 5'd0, 12'h0, 32'hFFFFF800, 1,
                    32'h80000293, 32'd0};
        vecs[8] = '{3'd2, 5'd0, 5'd0, 12'h0, 32'h00001000, 1,
                    32'h00001037, 32'd0};
`else
        vecs[3] = '{3'd2, 5'd5, 5'd0, 12'h0, 32'hFFFFF800, 2,
                    32'h000002B7, 32'h8002829B};
        vecs[8] = '{3'd2, 5'd0, 5'd0, 12'h0, 32'h00001000, 2,
                    32'h00001037, 32'h0000001B};
`endif
        vecs[4] = '{3'd3, 5'd7, 5'd3, 12'h0, 32'h00000010, 1,
                    32'h0101B383, 32'd0};
        vecs[5] = '{3'd5, 5'd0, 5'd0, 12'h0, 32'd0, 1,
                    32'h0000100F, 32'd0};
        vecs[6] = '{3'd6, 5'd1, 5'd1, 12'h1, 32'd1, 0, 32'd0, 32'd0};
        vecs[7] = '{3'd7, 5'd2, 5'd2, 12'h2, 32'd2, 0, 32'd0, 32'd0};

        reset_n_i    = 1'b0;
        cmd_v_i      = 1'b0;
        cmd_op_i     = 3'd0;
        cmd_rd_i     = 5'd0;
        cmd_rs1_i    = 5'd0;
        cmd_csr_i    = 12'd0;
        cmd_imm_i    = 32'd0;
        instr_yumi_i = 1'b0;
        #23;
        check("rst_ready", cmd_ready_o, 1);
        check("rst_valid", instr_v_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_exc", fe_exc_not_instr_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // yumi while idle must not disturb anything
        @(negedge clk_i);
        instr_yumi_i = 1'b1;
        @(negedge clk_i);
        instr_yumi_i = 1'b0;
        check("idle_yumi_v", instr_v_o, 0);
        check("idle_yumi_done", done_o, 0);
        check("idle_yumi_ready", cmd_ready_o, 1);

        // SD with a 5-cycle stall before the consumer takes it
        send(3'd4, 5'd6, 5'd2, 12'h0, 32'd8);
        for (int c = 0; c < 5; c++) begin
            check("sd_stall_v", instr_v_o, 1);
            check("sd_stall_instr", instr_o, 32'h00613423);
            check("sd_stall_ready", cmd_ready_o, 0);
            @(negedge clk_i);
        end
        instr_yumi_i = 1'b1;
        @(negedge clk_i);
        instr_yumi_i = 1'b0;
        check("sd_done", done_o, 1);
        check("sd_idle", instr_v_o, 0);

        // Reset asserted while the second LI word is pending
        send(3'd2, 5'd5, 5'd0, 12'h0, 32'h12345FFF);
        check("rstmid_w0", instr_o, 32'h123462B7);
        instr_yumi_i = 1'b1;
        @(negedge clk_i);
        instr_yumi_i = 1'b0;
        check("rstmid_w1", instr_o, 32'hFFF2829B);
        check("rstmid_v_pre", instr_v_o, 1);
        reset_n_i = 1'b0;
        #1;
        check("rstmid_v_async", instr_v_o, 0);
        check("rstmid_ready_async", cmd_ready_o, 1);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("rstmid_no_resid_v", instr_v_o, 0);
            check("rstmid_no_done", done_o, 0);
            check("rstmid_ready", cmd_ready_o, 1);
        end

        // Encoder must still work after the abandoned sequence
        run_vec(vecs[5], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
